neuromorphic_axi_lite_master: RTL

NEUROMORPHIC_AXI_LITE_MASTER -- requirements
Module: neuromorphic_axi_lite_master

---
 rtl/neuromorphic_axi_lite_master.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/neuromorphic_axi_lite_master.sv
// ---------------------------------------------------------------------------
// neuromorphic_axi_lite_master
//
// Turns single register commands (cmd_*) into AXI4-Lite write or read
// transactions and hands the slave's answer back on the rsp_* port. Only one
// transaction is in flight at a time: cmd_ready is high only while idle, and
// the response is held until the consumer takes it.
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESETN   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_write, cmd_addr,        1 = write / 0 = read, byte address,
//   cmd_wdata                   write data
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_resp,        read data (0 for writes), BRESP/RRESP,
//   rsp_timeout                 phase timed out
//   M_AXI_*                     AXI4-Lite master channels AW, W, B, AR, R
//
// Build option
//   NEUROMORPHIC_AXI_TIMEOUT_EN  when defined, every AXI phase is bounded to
//   TIMEOUT_CYCLES cycles; an expired phase is abandoned and reported as
//   rsp_timeout=1 with rsp_resp=SLVERR and rsp_rdata=0. When undefined the
//   FSM waits on the slave indefinitely and rsp_timeout is constant 0.
// ---------------------------------------------------------------------------
module neuromorphic_axi_lite_master #(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    // command
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    // response
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    // AXI4-Lite master
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_RSP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;

    // AW and W complete independently; both may land in the same cycle.
    logic aw_hs, w_hs, aw_done_nxt, w_done_nxt;
    assign aw_hs       = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs        = M_AXI_WVALID  && M_AXI_WREADY;
    assign aw_done_nxt = aw_done_q || aw_hs;
    assign w_done_nxt  = w_done_q  || w_hs;

    // High when the current phase is abandoned this cycle.
    logic timeout_hit;

`ifdef NEUROMORPHIC_AXI_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             waiting, phase_complete;

    assign waiting = (state_q == ST_WR_REQ)  || (state_q == ST_WR_RESP) ||
                     (state_q == ST_RD_REQ)  || (state_q == ST_RD_DATA);

    // A phase that completes in its last allowed cycle is not a timeout.
    assign phase_complete =
        ((state_q == ST_WR_REQ)  && aw_done_nxt && w_done_nxt) ||
        ((state_q == ST_WR_RESP) && M_AXI_BVALID)  ||
        ((state_q == ST_RD_REQ)  && M_AXI_ARREADY) ||
        ((state_q == ST_RD_DATA) && M_AXI_RVALID);

    assign timeout_hit = waiting && (cnt_q == CNT_LAST) && !phase_complete;

    // Counter restarts on every state change, so each phase gets its own budget.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        timeout_d = timeout_q;
        if ((state_q == ST_IDLE) && cmd_valid) begin
            timeout_d = 1'b0;
        end else if (timeout_hit) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign rsp_timeout = timeout_q;
`else
    logic cfg_unused;
    assign cfg_unused  = (TIMEOUT_CYCLES == 0);
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = cmd_write ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if (aw_done_nxt && w_done_nxt) state_d = ST_WR_RESP;
                else if (timeout_hit)          state_d = ST_RSP;
            end
            ST_WR_RESP: begin
                if (M_AXI_BVALID || timeout_hit) state_d = ST_RSP;
            end
            ST_RD_REQ: begin
                if (M_AXI_ARREADY)    state_d = ST_RD_DATA;
                else if (timeout_hit) state_d = ST_RSP;
            end
            ST_RD_DATA: begin
                if (M_AXI_RVALID || timeout_hit) state_d = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rdata_d   = '0;
                    resp_d    = 2'b00;
                end
            end
            ST_WR_REQ: begin
                aw_done_d = aw_done_nxt;
                w_done_d  = w_done_nxt;
            end
            ST_WR_RESP: begin
                if (M_AXI_BVALID) resp_d = M_AXI_BRESP;
            end
            ST_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                end
            end
            default: ;
        endcase
        if (timeout_hit) begin
            rdata_d = '0;
            resp_d  = 2'b10;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    // ---------------- outputs ----------------
    // All handshake outputs decode the state register directly, so the async
    // reset drops them in the same instant it forces IDLE.
    always_comb begin
        cmd_ready     = (state_q == ST_IDLE);
        rsp_valid     = (state_q == ST_RSP);
        M_AXI_AWVALID = (state_q == ST_WR_REQ) && !aw_done_q;
        M_AXI_WVALID  = (state_q == ST_WR_REQ) && !w_done_q;
        M_AXI_BREADY  = (state_q == ST_WR_RESP);
        M_AXI_ARVALID = (state_q == ST_RD_REQ);
        M_AXI_RREADY  = (state_q == ST_RD_DATA);
    end

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = '1;
    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;

endmodule
